// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types and constants
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int PC_W  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 3;

  // addi x0, x0, 0 -- what a bubble looks like in ID/EX
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX/WB observation and stall/flush/redirect
// control bundle between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int PC_W = pipe_hazard_ctrl_pkg::PC_W,
  parameter int RA_W = pipe_hazard_ctrl_pkg::RA_W
);

  logic            d_valid_i;
  logic [RA_W-1:0] d_rs1_i;
  logic [RA_W-1:0] d_rs2_i;
  logic            d_rs1_use_i;
  logic            d_rs2_use_i;
  logic            d_serial_i;
  logic            e_valid_i;
  logic            e_load_i;
  logic [RA_W-1:0] e_rd_i;
  logic            e_byp_en_i;
  logic            e_byp_cnd_i;
  logic [PC_W-1:0] e_target_i;
  logic            w_retire_i;
  logic            w_serial_i;
  logic            w_redir_i;
  logic [PC_W-1:0] w_target_i;

  logic            d_stall_o;
  logic            e_bubble_o;
  logic            d_flush_o;
  logic            f_hold_o;
  logic            redir_valid_o;
  logic [PC_W-1:0] redir_pc_o;
  logic            issue_o;
  logic            busy_o;

  modport master (
    output d_valid_i, d_rs1_i, d_rs2_i,
    output d_rs1_use_i, d_rs2_use_i, d_serial_i,
    output e_valid_i, e_load_i, e_rd_i,
    output e_byp_en_i, e_byp_cnd_i, e_target_i,
    output w_retire_i, w_serial_i,
    output w_redir_i, w_target_i,
    input  d_stall_o, e_bubble_o, d_flush_o,
    input  f_hold_o, redir_valid_o, redir_pc_o,
    input  issue_o, busy_o
  );

  modport slave (
    input  d_valid_i, d_rs1_i, d_rs2_i,
    input  d_rs1_use_i, d_rs2_use_i, d_serial_i,
    input  e_valid_i, e_load_i, e_rd_i,
    input  e_byp_en_i, e_byp_cnd_i, e_target_i,
    input  w_retire_i, w_serial_i,
    input  w_redir_i, w_target_i,
    output d_stall_o, e_bubble_o, d_flush_o,
    output f_hold_o, redir_valid_o, redir_pc_o,
    output issue_o, busy_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_inflight_cnt.sv
// pipe_hazard_ctrl_inflight_cnt: saturating up/down count of
// instructions between ID/EX and WB.
module pipe_hazard_ctrl_inflight_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10:   if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  a_ovf: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(inc_i && !dec_i && cnt_q == '1));

  a_unf: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(dec_i && cnt_q == '0));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, mispredict and serializing-instruction
// control for the in-order pipeline.
module pipe_hazard_ctrl #(
  parameter int PC_W  = pipe_hazard_ctrl_pkg::PC_W,
  parameter int RA_W  = pipe_hazard_ctrl_pkg::RA_W,
  parameter int CNT_W = pipe_hazard_ctrl_pkg::CNT_W
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_hazard_ctrl_if.slave h
);
  import pipe_hazard_ctrl_pkg::*;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] inflight;
  logic [RA_W-1:0]  e_rd;
  logic [PC_W-1:0]  redir_pc;
  logic             mispredict;
  logic             lu_haz;
  logic             serial_req;
  logic             drain_done;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             hold;
  logic             redir;
  logic             issue;

  assign e_rd       = h.e_rd_i;
  assign mispredict = h.e_valid_i & h.e_byp_en_i & h.e_byp_cnd_i;
  assign lu_haz     = h.e_valid_i & h.e_load_i & (e_rd != '0)
                    & h.d_valid_i
                    & ((h.d_rs1_use_i & (h.d_rs1_i == e_rd))
                    |  (h.d_rs2_use_i & (h.d_rs2_i == e_rd)));
  assign serial_req = h.d_valid_i & h.d_serial_i;
  // look at the post-retire count, not the registered one
  assign drain_done = (inflight == '0)
                    | ((inflight == CNT_W'(1)) & h.w_retire_i);

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    issue    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mispredict) begin
          flush    = 1'b1;
          bubble   = 1'b1;
          redir    = 1'b1;
          redir_pc = h.e_target_i;
        end else if (lu_haz) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else if (serial_req && inflight != '0) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = DRAIN;
        end else begin
          issue = h.d_valid_i;
          if (serial_req) begin
            hold    = 1'b1;
            state_d = SERIAL;
          end
        end
      end
      DRAIN: begin
        bubble = 1'b1;
        if (mispredict) begin
          flush    = 1'b1;
          redir    = 1'b1;
          redir_pc = h.e_target_i;
          state_d  = RUN;
        end else begin
          stall = 1'b1;
          if (drain_done) state_d = RUN;
        end
      end
      SERIAL: begin
        hold  = 1'b1;
        flush = 1'b1;
        if (h.w_retire_i && h.w_serial_i) begin
          redir    = 1'b1;
          redir_pc = h.w_target_i;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst_i) begin
      stall    = 1'b0;
      bubble   = 1'b0;
      flush    = 1'b0;
      hold     = 1'b0;
      redir    = 1'b0;
      redir_pc = '0;
      issue    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= RUN;
    else        state_q <= state_d;
  end

  pipe_hazard_ctrl_inflight_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (issue),
    .dec_i (h.w_retire_i),
    .cnt_o (inflight)
  );

  assign h.d_stall_o     = stall;
  assign h.e_bubble_o    = bubble;
  assign h.d_flush_o     = flush;
  assign h.f_hold_o      = hold;
  assign h.redir_valid_o = redir;
  assign h.redir_pc_o    = redir_pc;
  assign h.issue_o       = issue;
  assign h.busy_o        = rst_i & (state_q != RUN);

  a_mp_serial: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(mispredict && h.w_retire_i && h.w_serial_i));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of the hazard controller.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .h     (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.d_valid_i   = 1'b0;
    bus.d_rs1_i     = '0;
    bus.d_rs2_i     = '0;
    bus.d_rs1_use_i = 1'b0;
    bus.d_rs2_use_i = 1'b0;
    bus.d_serial_i  = 1'b0;
    bus.e_valid_i   = 1'b0;
    bus.e_load_i    = 1'b0;
    bus.e_rd_i      = '0;
    bus.e_byp_en_i  = 1'b0;
    bus.e_byp_cnd_i = 1'b0;
    bus.e_target_i  = '0;
    bus.w_retire_i  = 1'b0;
    bus.w_serial_i  = 1'b0;
    bus.w_redir_i   = 1'b0;
    bus.w_target_i  = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic plain(input logic ret);
    idle();
    bus.d_valid_i  = 1'b1;
    bus.w_retire_i = ret;
  endtask

  task automatic serial();
    idle();
    bus.d_valid_i  = 1'b1;
    bus.d_serial_i = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(bus.d_stall_o), 32'd0);
    chk({tag, "_bub"}, 32'(bus.e_bubble_o), 32'd0);
    chk({tag, "_flush"}, 32'(bus.d_flush_o), 32'd0);
    chk({tag, "_hold"}, 32'(bus.f_hold_o), 32'd0);
    chk({tag, "_rv"}, 32'(bus.redir_valid_o), 32'd0);
    chk({tag, "_rpc"}, bus.redir_pc_o, 32'd0);
    chk({tag, "_iss"}, 32'(bus.issue_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    idle();
    // reset with live inputs: outputs forced low
    bus.d_valid_i   = 1'b1;
    bus.e_valid_i   = 1'b1;
    bus.e_byp_en_i  = 1'b1;
    bus.e_byp_cnd_i = 1'b1;
    bus.e_target_i  = 32'h8000_0040;
    @(negedge clk);
    chk_zero("rst");
    chk("rst_inf", 32'(dut.inflight), 32'd0);
    nxt();
    rst_n = 1'b1;
    idle();

    // load-use on rs2
    bus.e_valid_i   = 1'b1;
    bus.e_load_i    = 1'b1;
    bus.e_rd_i      = 5'd5;
    bus.d_valid_i   = 1'b1;
    bus.d_rs2_i     = 5'd5;
    bus.d_rs2_use_i = 1'b1;
    @(negedge clk);
    chk("lu_stall", 32'(bus.d_stall_o), 32'd1);
    chk("lu_bub", 32'(bus.e_bubble_o), 32'd1);
    chk("lu_iss", 32'(bus.issue_o), 32'd0);
    nxt();
    bus.e_valid_i = 1'b0;
    @(negedge clk);
    chk("lu2_stall", 32'(bus.d_stall_o), 32'd0);
    chk("lu2_iss", 32'(bus.issue_o), 32'd1);
    nxt();

    // x0 never hazards
    bus.e_valid_i   = 1'b1;
    bus.e_rd_i      = 5'd0;
    bus.d_rs1_i     = 5'd0;
    bus.d_rs1_use_i = 1'b1;
    bus.d_rs2_i     = 5'd0;
    @(negedge clk);
    chk("x0_stall", 32'(bus.d_stall_o), 32'd0);
    chk("x0_iss", 32'(bus.issue_o), 32'd1);
    nxt();
    chk("inf_2", 32'(dut.inflight), 32'd2);

    // mispredict beats load-use
    idle();
    bus.e_valid_i   = 1'b1;
    bus.e_load_i    = 1'b1;
    bus.e_rd_i      = 5'd7;
    bus.e_byp_en_i  = 1'b1;
    bus.e_byp_cnd_i = 1'b1;
    bus.e_target_i  = 32'h8000_0040;
    bus.d_valid_i   = 1'b1;
    bus.d_rs1_i     = 5'd7;
    bus.d_rs1_use_i = 1'b1;
    @(negedge clk);
    chk("mp_rv", 32'(bus.redir_valid_o), 32'd1);
    chk("mp_pc", bus.redir_pc_o, 32'h8000_0040);
    chk("mp_flush", 32'(bus.d_flush_o), 32'd1);
    chk("mp_bub", 32'(bus.e_bubble_o), 32'd1);
    chk("mp_stall", 32'(bus.d_stall_o), 32'd0);
    chk("mp_iss", 32'(bus.issue_o), 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("mp_inf", 32'(dut.inflight), 32'd2);
    chk("mp_rv0", 32'(bus.redir_valid_o), 32'd0);
    nxt();

    // CSR with two older instructions in flight
    serial();
    @(negedge clk);
    chk("csr0_stall", 32'(bus.d_stall_o), 32'd1);
    chk("csr0_bub", 32'(bus.e_bubble_o), 32'd1);
    chk("csr0_busy", 32'(bus.busy_o), 32'd0);
    nxt();
    @(negedge clk);
    chk("csr1_busy", 32'(bus.busy_o), 32'd1);
    chk("csr1_stall", 32'(bus.d_stall_o), 32'd1);
    chk("csr1_iss", 32'(bus.issue_o), 32'd0);
    nxt();
    bus.w_retire_i = 1'b1;
    @(negedge clk);
    chk("csr2_stall", 32'(bus.d_stall_o), 32'd1);
    nxt();
    bus.w_retire_i = 1'b0;
    @(negedge clk);
    chk("csr3_stall", 32'(bus.d_stall_o), 32'd1);
    chk("csr3_inf", 32'(dut.inflight), 32'd1);
    nxt();
    bus.w_retire_i = 1'b1;
    @(negedge clk);
    chk("csr4_stall", 32'(bus.d_stall_o), 32'd1);
    chk("csr4_busy", 32'(bus.busy_o), 32'd1);
    nxt();
    bus.w_retire_i = 1'b0;
    @(negedge clk);
    chk("csr5_busy", 32'(bus.busy_o), 32'd0);
    chk("csr5_stall", 32'(bus.d_stall_o), 32'd0);
    chk("csr5_iss", 32'(bus.issue_o), 32'd1);
    chk("csr5_hold", 32'(bus.f_hold_o), 32'd1);
    nxt();
    plain(1'b0);
    @(negedge clk);
    chk("ser_busy", 32'(bus.busy_o), 32'd1);
    chk("ser_hold", 32'(bus.f_hold_o), 32'd1);
    chk("ser_flush", 32'(bus.d_flush_o), 32'd1);
    chk("ser_iss", 32'(bus.issue_o), 32'd0);
    chk("ser_rv", 32'(bus.redir_valid_o), 32'd0);
    nxt();
    idle();
    bus.w_retire_i = 1'b1;
    bus.w_serial_i = 1'b1;
    bus.w_redir_i  = 1'b1;
    bus.w_target_i = 32'h8000_0100;
    @(negedge clk);
    chk("sret_rv", 32'(bus.redir_valid_o), 32'd1);
    chk("sret_pc", bus.redir_pc_o, 32'h8000_0100);
    nxt();
    idle();
    @(negedge clk);
    chk("post_busy", 32'(bus.busy_o), 32'd0);
    chk("post_hold", 32'(bus.f_hold_o), 32'd0);
    chk("post_inf", 32'(dut.inflight), 32'd0);
    nxt();

    // older branch kills a draining CSR
    plain(1'b0);
    nxt();
    plain(1'b0);
    nxt();
    serial();
    nxt();
    bus.e_valid_i   = 1'b1;
    bus.e_byp_en_i  = 1'b1;
    bus.e_byp_cnd_i = 1'b1;
    bus.e_target_i  = 32'h8000_0200;
    @(negedge clk);
    chk("dmp_busy", 32'(bus.busy_o), 32'd1);
    chk("dmp_flush", 32'(bus.d_flush_o), 32'd1);
    chk("dmp_rv", 32'(bus.redir_valid_o), 32'd1);
    chk("dmp_pc", bus.redir_pc_o, 32'h8000_0200);
    chk("dmp_iss", 32'(bus.issue_o), 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("dmp_run", 32'(bus.busy_o), 32'd0);
    chk("dmp_inf", 32'(dut.inflight), 32'd2);
    nxt();

    // issue and retire together keep the count flat
    for (int i = 0; i < 20; i++) begin
      plain(1'b1);
      @(negedge clk);
      chk($sformatf("b2b_iss%0d", i), 32'(bus.issue_o), 32'd1);
      nxt();
      chk($sformatf("b2b_inf%0d", i), 32'(dut.inflight), 32'd2);
    end

    // async reset in DRAIN with three in flight
    plain(1'b0);
    nxt();
    serial();
    nxt();
    @(negedge clk);
    chk("dr3_busy", 32'(bus.busy_o), 32'd1);
    chk("dr3_inf", 32'(dut.inflight), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("arst_d");
    chk("arst_d_inf", 32'(dut.inflight), 32'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_hold", 32'(bus.f_hold_o), 32'd1);
    chk("rs_iss", 32'(bus.issue_o), 32'd1);
    nxt();
    @(negedge clk);
    chk("rs_busy", 32'(bus.busy_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("arst_s");
    chk("arst_s_inf", 32'(dut.inflight), 32'd0);
    nxt();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
